// File: rtl/sram8_bus_bridge_pkg.sv
// Shared definitions for the 8-bit SRAM bus bridge: FSM states, mask constants
// and byte-lane helpers.
package sram8_bus_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] MASK_NONE = 4'b0000;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    // Lowest set lane of a byte mask; an empty mask maps to lane 0.
    function automatic logic [1:0] lowest_idx(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        if (m[0])      r = 2'd0;
        else if (m[1]) r = 2'd1;
        else if (m[2]) r = 2'd2;
        else if (m[3]) r = 2'd3;
        return r;
    endfunction

    function automatic logic [3:0] idx_bit(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/sram8_byte_seq.sv
// Per-byte timing for the SRAM cycle: one setup cycle, then WAIT_CYCLES strobe
// cycles, with a pulse on the final strobe cycle.
module sram8_byte_seq #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    output logic strobe,
    output logic last
);

    localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

    // Phase 0 is the setup cycle, phases 1..WAIT_CYCLES are strobe cycles.
    logic [CW-1:0] cnt_reg;

    assign strobe = active && (cnt_reg != '0);
    assign last   = active && (cnt_reg == CW'(WAIT_CYCLES));

    always_ff @(posedge clk) begin
        if (reset || !active || last) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

endmodule

// File: rtl/sram8_bus_bridge.sv
// Bridges the core's 32-bit word bus onto an 8-bit asynchronous SRAM, moving one
// byte per SRAM cycle and holding the core meanwhile; keeps a one-word read buffer.
module sram8_bus_bridge
    import sram8_bus_bridge_pkg::*;
#(
    parameter int ADDR_W      = 19,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       cpu_addr,
    input  logic [3:0]        cpu_wmask,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_hold,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [7:0]        ext_wdata,
    input  logic [7:0]        ext_rdata,
    output logic              ext_ce,
    output logic              ext_oe,
    output logic              ext_we
);

    localparam int TW = ADDR_W - 2;

    state_t          state_reg, state_next;
    logic [TW-1:0]   addr_reg, addr_next;
    logic [3:0]      mask_reg, mask_next;
    logic [3:0]      rem_reg, rem_next;
    logic            wr_reg, wr_next;
    logic [31:0]     wdata_reg, wdata_next;
    logic [1:0]      idx_reg, idx_next;
    logic            buf_valid_reg, buf_valid_next;
    logic [TW-1:0]   buf_tag_reg, buf_tag_next;
    logic            wr_done_reg, wr_done_next;
    logic            armed_reg;

    logic [TW-1:0]   cpu_word;
    logic            idle, active;
    logic            wr_done_eff, rd_miss, wr_req;
    logic            seq_strobe, seq_last;
    logic [3:0]      rem_left;
    logic            unused_addr_bits;

    assign cpu_word         = cpu_addr[ADDR_W-1:2];
    assign unused_addr_bits = ^{cpu_addr[31:ADDR_W], cpu_addr[1:0]};

    assign idle   = (state_reg == ST_IDLE);
    assign active = (state_reg == ST_SETUP) || (state_reg == ST_STROBE);

    // A finished store stays finished until the core moves off that word or stops
    // writing; evaluated combinationally so a new store is seen in its first cycle.
    assign wr_done_eff = wr_done_reg && (cpu_wmask != MASK_NONE) && (cpu_word == addr_reg);
    // No request is taken in the first cycle out of reset.
    assign rd_miss = armed_reg && idle && (cpu_wmask == MASK_NONE) &&
                     (!buf_valid_reg || (cpu_word != buf_tag_reg));
    assign wr_req  = armed_reg && idle && (cpu_wmask != MASK_NONE) && !wr_done_eff;

    assign cpu_hold = active || rd_miss || wr_req;

    assign ext_ce    = active;
    assign ext_oe    = active && !wr_reg;
    assign ext_we    = seq_strobe && wr_reg;
    assign ext_addr  = active ? {addr_reg, idx_reg} : '0;
    assign ext_wdata = (active && wr_reg) ? wdata_reg[8*idx_reg +: 8] : 8'h00;

    sram8_byte_seq #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_seq (
        .clk    (clk),
        .reset  (reset),
        .active (active),
        .strobe (seq_strobe),
        .last   (seq_last)
    );

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        mask_next      = mask_reg;
        rem_next       = rem_reg;
        wr_next        = wr_reg;
        wdata_next     = wdata_reg;
        idx_next       = idx_reg;
        buf_valid_next = buf_valid_reg;
        buf_tag_next   = buf_tag_reg;
        wr_done_next   = wr_done_reg;
        rem_left       = rem_reg & ~idx_bit(idx_reg);

        case (state_reg)
            ST_IDLE: begin
                wr_done_next = wr_done_eff;
                if (wr_req) begin
                    addr_next  = cpu_word;
                    mask_next  = cpu_wmask;
                    rem_next   = cpu_wmask;
                    wr_next    = 1'b1;
                    wdata_next = cpu_wdata;
                    idx_next   = lowest_idx(cpu_wmask);
                    state_next = ST_SETUP;
                end else if (rd_miss) begin
                    addr_next      = cpu_word;
                    mask_next      = MASK_WORD;
                    rem_next       = MASK_WORD;
                    wr_next        = 1'b0;
                    wdata_next     = cpu_wdata;
                    idx_next       = 2'd0;
                    buf_valid_next = 1'b0;
                    state_next     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_next = ST_STROBE;
            end
            ST_STROBE: begin
                if (seq_last) begin
                    rem_next = rem_left;
                    if (rem_left != MASK_NONE) begin
                        idx_next   = lowest_idx(rem_left);
                        state_next = ST_SETUP;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                if (wr_reg) begin
                    wr_done_next = 1'b1;
                end else begin
                    buf_valid_next = 1'b1;
                    buf_tag_next   = addr_reg;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= '0;
            mask_reg      <= MASK_NONE;
            rem_reg       <= MASK_NONE;
            wr_reg        <= 1'b0;
            wdata_reg     <= '0;
            idx_reg       <= 2'd0;
            buf_valid_reg <= 1'b0;
            buf_tag_reg   <= '0;
            wr_done_reg   <= 1'b0;
            armed_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            mask_reg      <= mask_next;
            rem_reg       <= rem_next;
            wr_reg        <= wr_next;
            wdata_reg     <= wdata_next;
            idx_reg       <= idx_next;
            buf_valid_reg <= buf_valid_next;
            buf_tag_reg   <= buf_tag_next;
            wr_done_reg   <= wr_done_next;
            armed_reg     <= 1'b1;
        end
    end

    // Each lane of the word buffer is filled by read captures and patched by
    // write-through when a store lands on the buffered word.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : gen_lane
            logic [7:0] byte_reg;
            logic       cap, thru;

            assign cap  = (state_reg == ST_STROBE) && seq_last && !wr_reg &&
                          (idx_reg == 2'(gi));
            assign thru = (state_reg == ST_DONE) && wr_reg && buf_valid_reg &&
                          (addr_reg == buf_tag_reg) && mask_reg[gi];

            always_ff @(posedge clk) begin
                if (reset) begin
                    byte_reg <= 8'h00;
                end else if (cap) begin
                    byte_reg <= ext_rdata;
                end else if (thru) begin
                    byte_reg <= wdata_reg[8*gi +: 8];
                end
            end

            assign cpu_rdata[8*gi +: 8] = byte_reg;
        end
    endgenerate

endmodule

// File: tb/tb_sram8_bus_bridge.sv
// Directed bench for sram8_bus_bridge: reset, read miss/hit, byte and word
// stores, and reset in the middle of a read.
module tb_sram8_bus_bridge;

    logic        clk;
    logic        reset;
    logic [31:0] cpu_addr;
    logic [3:0]  cpu_wmask;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_hold;
    logic [18:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic [7:0]  ext_rdata;
    logic        ext_ce;
    logic        ext_oe;
    logic        ext_we;

    int checks   = 0;
    int failures = 0;

    logic [18:0] rd_q[$];
    logic [18:0] wa_q[$];
    logic [7:0]  wd_q[$];
    int          hold_cnt;
    logic        any_hold, any_ce;

    sram8_bus_bridge #(
        .ADDR_W(19),
        .WAIT_CYCLES(1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wmask (cpu_wmask),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_hold  (cpu_hold),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_rdata (ext_rdata),
        .ext_ce    (ext_ce),
        .ext_oe    (ext_oe),
        .ext_we    (ext_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM contents, returned combinationally while selected.
    function automatic logic [7:0] sram_byte(input logic [18:0] a);
        case (a)
            19'h10074: return 8'h13;
            19'h00200: return 8'hA1;
            19'h00201: return 8'hB2;
            19'h00202: return 8'hC3;
            19'h00203: return 8'hD4;
            default:   return 8'h00;
        endcase
    endfunction

    always_comb begin
        ext_rdata = 8'h00;
        if (ext_ce && ext_oe) ext_rdata = sram_byte(ext_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starting on a held sample, step until hold drops, logging SRAM traffic.
    task automatic measure();
        hold_cnt = 0;
        rd_q.delete();
        wa_q.delete();
        wd_q.delete();
        for (int i = 0; i < 40 && cpu_hold; i++) begin
            hold_cnt++;
            if (ext_ce && ext_oe && (rd_q.size() == 0 || rd_q[rd_q.size()-1] != ext_addr))
                rd_q.push_back(ext_addr);
            if (ext_we) begin
                wa_q.push_back(ext_addr);
                wd_q.push_back(ext_wdata);
            end
            step();
        end
    endtask

    function automatic logic [31:0] rd_at(input int i);
        return (i < rd_q.size()) ? {13'd0, rd_q[i]} : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] wa_at(input int i);
        return (i < wa_q.size()) ? {13'd0, wa_q[i]} : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] wd_at(input int i);
        return (i < wd_q.size()) ? {24'd0, wd_q[i]} : 32'hFFFF_FFFF;
    endfunction

    initial begin
        logic [7:0] word_bytes [4];
        word_bytes[0] = 8'h44;
        word_bytes[1] = 8'h33;
        word_bytes[2] = 8'h22;
        word_bytes[3] = 8'h11;

        // Reset held for three cycles with random bus activity.
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cpu_addr  = $urandom;
            cpu_wmask = 4'($urandom);
            cpu_wdata = $urandom;
            @(posedge clk);
        end
        #1;
        reset     = 1'b0;
        cpu_addr  = 32'h0001_0074;
        cpu_wmask = 4'b0000;
        cpu_wdata = 32'h0;
        #1;
        check("reset_hold",  {31'd0, cpu_hold}, 32'd0);
        check("reset_ce",    {31'd0, ext_ce},   32'd0);
        check("reset_oe",    {31'd0, ext_oe},   32'd0);
        check("reset_we",    {31'd0, ext_we},   32'd0);
        check("reset_addr",  {13'd0, ext_addr}, 32'd0);
        check("reset_rdata", cpu_rdata,         32'd0);
        $display("txn reset hold=%0b rdata=0x%08h", cpu_hold, cpu_rdata);

        // Read miss on 0x00010074.
        step();
        measure();
        check("miss_hold_len", hold_cnt, 32'd9);
        for (int i = 0; i < 4; i++)
            check($sformatf("miss_addr%0d", i), rd_at(i), 32'h0001_0074 + i);
        check("miss_rdata_done", cpu_rdata, 32'h0000_0013);
        check("miss_ce_done", {31'd0, ext_ce}, 32'd0);
        $display("txn read_miss addr=0x00010074 hold=%0d rdata=0x%08h", hold_cnt, cpu_rdata);

        // Read hit on the same word.
        cpu_addr = 32'h0001_0076;
        any_hold = 1'b0;
        any_ce   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            any_hold |= cpu_hold;
            any_ce   |= ext_ce;
        end
        check("hit_hold",  {31'd0, any_hold}, 32'd0);
        check("hit_ce",    {31'd0, any_ce},   32'd0);
        check("hit_rdata", cpu_rdata,         32'h0000_0013);
        $display("txn read_hit addr=0x00010076 rdata=0x%08h", cpu_rdata);

        // Byte store into the buffered word.
        cpu_addr  = 32'h0001_0075;
        cpu_wmask = 4'b0010;
        cpu_wdata = 32'hAAAA_AAAA;
        #1;
        measure();
        check("bst_hold_len", hold_cnt,           32'd3);
        check("bst_we_count", wa_q.size(),        32'd1);
        check("bst_we_addr",  wa_at(0),           32'h0001_0075);
        check("bst_we_data",  wd_at(0),           32'h0000_00AA);
        any_hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            any_hold |= cpu_hold;
        end
        check("bst_no_retrig", {31'd0, any_hold}, 32'd0);
        check("bst_rdata",     cpu_rdata,         32'h0000_AA13);
        $display("txn byte_store addr=0x00010075 hold=%0d rdata=0x%08h", hold_cnt, cpu_rdata);

        // Word store to an unbuffered word.
        cpu_addr  = 32'h0000_0100;
        cpu_wmask = 4'b1111;
        cpu_wdata = 32'h1122_3344;
        #1;
        measure();
        check("wst_hold_len", hold_cnt,    32'd9);
        check("wst_we_count", wa_q.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wst_we_addr%0d", i), wa_at(i), 32'h0000_0100 + i);
            check($sformatf("wst_we_data%0d", i), wd_at(i), {24'd0, word_bytes[i]});
        end
        any_hold = 1'b0;
        any_ce   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            any_hold |= cpu_hold;
            any_ce   |= ext_ce;
        end
        check("wst_no_retrig", {31'd0, any_hold}, 32'd0);
        check("wst_no_ce",     {31'd0, any_ce},   32'd0);
        check("wst_rdata",     cpu_rdata,         32'h0000_AA13);
        $display("txn word_store addr=0x00000100 hold=%0d pulses=%0d", hold_cnt, wa_q.size());

        // Read miss on 0x200, interrupted by reset in its second strobe.
        cpu_addr  = 32'h0000_0200;
        cpu_wmask = 4'b0000;
        #1;
        check("mid_hold_start", {31'd0, cpu_hold}, 32'd1);
        for (int i = 0; i < 4; i++) step();
        check("mid_ce_strobe2", {31'd0, ext_ce},   32'd1);
        check("mid_addr_strobe2", {13'd0, ext_addr}, 32'h0000_0201);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("mid_ce",    {31'd0, ext_ce},   32'd0);
        check("mid_oe",    {31'd0, ext_oe},   32'd0);
        check("mid_we",    {31'd0, ext_we},   32'd0);
        check("mid_hold",  {31'd0, cpu_hold}, 32'd0);
        check("mid_rdata", cpu_rdata,         32'd0);
        $display("txn reset_mid_read rdata=0x%08h", cpu_rdata);

        // Re-issue: the whole word is fetched again.
        step();
        measure();
        check("refetch_hold_len", hold_cnt, 32'd9);
        for (int i = 0; i < 4; i++)
            check($sformatf("refetch_addr%0d", i), rd_at(i), 32'h0000_0200 + i);
        check("refetch_rdata", cpu_rdata, 32'hD4C3_B2A1);
        $display("txn refetch addr=0x00000200 hold=%0d rdata=0x%08h", hold_cnt, cpu_rdata);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
